// File: rtl/leiwand_rv32_bus_decoder.sv
// Single-master, N-slave interconnect for the leiwand_rv32 valid/ready bus.
// Decodes base/mask windows and returns a registered response, with bus errors for unmapped or hung accesses.
module leiwand_rv32_bus_decoder #(
  parameter int unsigned                   XLEN           = 32,
  parameter int unsigned                   NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*XLEN-1:0]    SLAVE_BASE     = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [NUM_SLAVES*XLEN-1:0]    SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter int unsigned                   TIMEOUT_CYCLES = 255,
  parameter logic [XLEN-1:0]               ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_m_valid,
  output logic                         o_m_ready,
  input  logic [XLEN-1:0]              i_m_addr,
  input  logic [XLEN-1:0]              i_m_wdata,
  input  logic [XLEN/8-1:0]            i_m_wen,
  output logic [XLEN-1:0]              o_m_rdata,
  output logic                         o_m_err,
  output logic [NUM_SLAVES-1:0]        o_s_valid,
  input  logic [NUM_SLAVES-1:0]        i_s_ready,
  output logic [XLEN-1:0]              o_s_addr,
  output logic [XLEN-1:0]              o_s_wdata,
  output logic [XLEN/8-1:0]            o_s_wen,
  input  logic [NUM_SLAVES*XLEN-1:0]   i_s_rdata,
  output logic [7:0]                   o_err_count
);

  localparam int unsigned SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [SEL_W-1:0]        sel, sel_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [NUM_SLAVES-1:0]   s_valid_nxt;
  logic                    m_ready_nxt;
  logic                    m_err_nxt;
  logic [XLEN-1:0]         m_rdata_nxt;
  logic [7:0]              err_count_nxt;
  logic                    err_evt;
  logic                    dec_hit;
  logic [SEL_W-1:0]        dec_sel;

  assign o_s_addr  = i_m_addr;
  assign o_s_wdata = i_m_wdata;
  assign o_s_wen   = i_m_wen;

  // Address decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((i_m_addr & SLAVE_MASK[i*XLEN +: XLEN]) ==
          (SLAVE_BASE[i*XLEN +: XLEN] & SLAVE_MASK[i*XLEN +: XLEN])) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end else begin
        dec_hit = dec_hit;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    cnt_nxt       = cnt;
    s_valid_nxt   = o_s_valid;
    m_ready_nxt   = 1'b0;
    m_err_nxt     = o_m_err;
    m_rdata_nxt   = o_m_rdata;
    err_count_nxt = o_err_count;
    err_evt       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!i_m_valid) begin
          state_nxt = IDLE;
        end else if (dec_hit) begin
          sel_nxt     = dec_sel;
          s_valid_nxt = NUM_SLAVES'(1) << dec_sel;
          state_nxt   = ACTIVE;
        end else begin
          m_rdata_nxt = ERR_RDATA;
          m_err_nxt   = 1'b1;
          m_ready_nxt = 1'b1;
          err_evt     = 1'b1;
          state_nxt   = RESP;
        end
      end
      ACTIVE: begin
        // Abort beats ready; ready beats timeout in the same cycle.
        if (!i_m_valid) begin
          s_valid_nxt = '0;
          cnt_nxt     = '0;
          state_nxt   = IDLE;
        end else if (i_s_ready[sel]) begin
          m_rdata_nxt = i_s_rdata[sel*XLEN +: XLEN];
          m_err_nxt   = 1'b0;
          m_ready_nxt = 1'b1;
          s_valid_nxt = '0;
          state_nxt   = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
          m_rdata_nxt = ERR_RDATA;
          m_err_nxt   = 1'b1;
          m_ready_nxt = 1'b1;
          err_evt     = 1'b1;
          s_valid_nxt = '0;
          state_nxt   = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        s_valid_nxt = '0;
        cnt_nxt     = '0;
        state_nxt   = IDLE;
      end
    endcase
    if (err_evt && (o_err_count != 8'hFF)) begin
      err_count_nxt = o_err_count + 8'd1;
    end else begin
      err_count_nxt = o_err_count;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      o_s_valid   <= '0;
      o_m_ready   <= 1'b0;
      o_m_err     <= 1'b0;
      o_m_rdata   <= '0;
      o_err_count <= 8'd0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      cnt         <= cnt_nxt;
      o_s_valid   <= s_valid_nxt;
      o_m_ready   <= m_ready_nxt;
      o_m_err     <= m_err_nxt;
      o_m_rdata   <= m_rdata_nxt;
      o_err_count <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_bus_decoder.sv
// Directed bench for leiwand_rv32_bus_decoder: vector table plus reset, abort and saturation sequences.
module tb_leiwand_rv32_bus_decoder;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NS   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m_valid = 1'b0;
  logic              m_ready;
  logic [31:0]       m_addr = 32'h0;
  logic [31:0]       m_wdata = 32'h0;
  logic [3:0]        m_wen = 4'h0;
  logic [31:0]       m_rdata;
  logic              m_err;
  logic [NS-1:0]     s_valid;
  logic [NS-1:0]     s_ready;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wen;
  logic [NS*32-1:0]  s_rdata;
  logic [7:0]        err_count;

  int                lat [NS] = '{-1, -1, -1};
  int                vcnt [NS] = '{0, 0, 0};
  logic [NS-1:0]     junk_ready = 3'b000;
  int                n_checks = 0;
  int                n_fail = 0;
  int                exp_errs = 0;

  assign s_rdata = {32'hCAFE_0002, 32'h0BAD_F00D, 32'h1234_5678};

  leiwand_rv32_bus_decoder #(
    .XLEN(XLEN),
    .NUM_SLAVES(NS),
    .SLAVE_BASE({32'h1000_0000, 32'h0200_0000, 32'h8000_0000}),
    .SLAVE_MASK({32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_F000}),
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_m_valid(m_valid), .o_m_ready(m_ready),
    .i_m_addr(m_addr), .i_m_wdata(m_wdata), .i_m_wen(m_wen),
    .o_m_rdata(m_rdata), .o_m_err(m_err),
    .o_s_valid(s_valid), .i_s_ready(s_ready),
    .o_s_addr(s_addr), .o_s_wdata(s_wdata), .o_s_wen(s_wen),
    .i_s_rdata(s_rdata), .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  // Slave model: ready after lat[i] cycles of valid; -1 means never.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) vcnt[i] <= s_valid[i] ? vcnt[i] + 1 : 0;
  end

  always_comb begin
    s_ready = junk_ready;
    for (int i = 0; i < NS; i++)
      if (s_valid[i] && lat[i] >= 0 && vcnt[i] == lat[i]) s_ready[i] = 1'b1;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    int          l0, l1, l2;
    logic [2:0]  junk;
    logic [2:0]  onehot;
    int          vcyc;
    int          rlat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int cyc, vcyc;
    logic bad, seen;
    lat[0] = v.l0; lat[1] = v.l1; lat[2] = v.l2;
    junk_ready = v.junk;
    @(negedge clk);
    m_valid = 1'b1; m_addr = v.addr; m_wdata = v.wdata; m_wen = v.wen;
    cyc = 0; vcyc = 0; bad = 1'b0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (s_valid != 3'b000) begin
        vcyc++;
        if (s_valid !== v.onehot) bad = 1'b1;
      end
      if (cyc == 1) check({tag, " passthru"}, {s_addr, s_wdata, s_wen}, {v.addr, v.wdata, v.wen});
      if (m_ready) seen = 1'b1;
    end
    check({tag, " ready_seen"}, seen, 1'b1);
    check({tag, " latency"}, cyc, v.rlat);
    check({tag, " err"}, m_err, v.err);
    check({tag, " rdata"}, m_rdata, v.rdata);
    check({tag, " valid_cycles"}, vcyc, v.vcyc);
    check({tag, " valid_onehot_bad"}, bad, 1'b0);
    if (v.err && exp_errs < 255) exp_errs++;
    m_valid = 1'b0; m_wen = 4'h0;
    @(negedge clk);
    check({tag, " single_pulse"}, m_ready, 1'b0);
    check({tag, " err_count"}, err_count, exp_errs);
    lat[0] = -1; lat[1] = -1; lat[2] = -1;
    junk_ready = 3'b000;
  endtask

  initial begin
    vec_t t;
    bit quiet;
    //          addr          wdata         wen   l0  l1  l2  junk    onehot  vc rl err   rdata
    vecs[0] = '{32'h8000_0004, 32'h0,        4'h0,  0, -1, -1, 3'b000, 3'b001, 1, 2, 1'b0, 32'h1234_5678};
    vecs[1] = '{32'h1000_0000, 32'h41,       4'h1, -1, -1,  2, 3'b000, 3'b100, 3, 4, 1'b0, 32'hCAFE_0002};
    vecs[2] = '{32'h4000_0000, 32'h0,        4'h0, -1, -1, -1, 3'b000, 3'b000, 0, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0200_BFF8, 32'h0,        4'h0, -1, -1, -1, 3'b101, 3'b010, 8, 9, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{32'h0200_0010, 32'h0,        4'h0, -1,  7, -1, 3'b000, 3'b010, 8, 9, 1'b0, 32'h0BAD_F00D};
    vecs[5] = '{32'h1000_000F, 32'hA5A5_5A5A, 4'hF, -1, -1,  1, 3'b000, 3'b100, 2, 3, 1'b0, 32'hCAFE_0002};
    vecs[6] = '{32'h1000_0010, 32'h0,        4'h0, -1, -1, -1, 3'b000, 3'b000, 0, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[7] = '{32'h8000_0FFC, 32'h0,        4'h0,  0, -1, -1, 3'b000, 3'b001, 1, 2, 1'b0, 32'h1234_5678};
    vecs[8] = '{32'h8000_1000, 32'h0,        4'h0, -1, -1, -1, 3'b000, 3'b000, 0, 1, 1'b1, 32'hDEAD_BEEF};

    #12;
    check("reset state", {m_ready, m_err, m_rdata, s_valid, err_count}, 45'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Master abort mid-ACTIVE: no response, slave valid drops.
    lat[1] = -1;
    @(negedge clk); m_valid = 1'b1; m_addr = 32'h0200_BFF8;
    repeat (3) @(negedge clk);
    check("abort valid before", s_valid, 3'b010);
    m_valid = 1'b0;
    @(negedge clk);
    check("abort valid dropped", s_valid, 3'b000);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (m_ready) quiet = 1'b0;
    end
    check("abort no response", quiet, 1'b1);
    check("abort err_count", err_count, exp_errs);
    run_txn(vecs[0], "after abort");

    // Async reset in the middle of an ACTIVE transaction.
    @(negedge clk); m_valid = 1'b1; m_addr = 32'h0200_BFF8;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid reset outputs", {m_ready, m_err, m_rdata, s_valid, err_count}, 45'h0);
    m_valid = 1'b0;
    exp_errs = 0;
    @(negedge clk); rst_n = 1'b1;
    t = vecs[0]; t.addr = 32'h8000_0000;
    run_txn(t, "after reset");

    // Repeated timeouts drive the error counter into saturation.
    for (int i = 0; i < 300; i++) run_txn(vecs[3], "sat");
    check("err_count saturated", err_count, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
